// File: rtl/game_pkg.sv
`default_nettype none
// ============================================================================
// Module      : game_pkg
// Description : Shared types and constants for the round timer and the HUD
//               digit drawing stage.
//               - timer_state_t : round timer FSM encoding
//               - GAME_TIME_S   : default round length in seconds
//               - LOW_TIME_S    : default low-time warning threshold in seconds
//               - to_bcd()      : 0..99 binary to packed {tens, ones} BCD
// Revision    : 1.0 - initial release
// ============================================================================
package game_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        EXPIRED = 2'd2
    } timer_state_t;

    localparam int GAME_TIME_S = 60;
    localparam int LOW_TIME_S  = 10;

    // Only ever evaluated on constants (reset/load values); the divide never
    // reaches a datapath.
    function automatic logic [7:0] to_bcd(input logic [6:0] value);
        return {4'(value / 7'd10), 4'(value % 7'd10)};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bcd_down_counter.sv
`default_nettype none
// ============================================================================
// Module      : bcd_down_counter
// Description : Two-digit BCD down counter with synchronous load and a zero
//               flag. Decrements stop at 00 so the digits never underflow.
// Ports       : clk        in   system clock
//               rst        in   synchronous active-high reset (-> RESET_BCD)
//               load       in   load load_value (wins over dec)
//               load_value in   8  packed {tens, ones} BCD load value
//               dec        in   decrement by one
//               tens       out  4  tens digit
//               ones       out  4  ones digit
//               zero       out  1  both digits are zero
// Revision    : 1.0 - initial release
// ============================================================================
module bcd_down_counter #(
    parameter logic [7:0] RESET_BCD = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] load_value,
    input  logic       dec,
    output logic [3:0] tens,
    output logic [3:0] ones,
    output logic       zero
);

    logic [3:0] r_tens;
    logic [3:0] r_ones;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_tens <= RESET_BCD[7:4];
            r_ones <= RESET_BCD[3:0];
        end else if (load) begin
            r_tens <= load_value[7:4];
            r_ones <= load_value[3:0];
        end else if (dec && !zero) begin
            if (r_ones == 4'd0) begin
                r_ones <= 4'd9;
                r_tens <= r_tens - 4'd1;
            end else begin
                r_ones <= r_ones - 4'd1;
            end
        end
    end

    assign tens = r_tens;
    assign ones = r_ones;
    assign zero = (r_tens == 4'd0) && (r_ones == 4'd0);

endmodule
`default_nettype wire

// File: rtl/game_timer.sv
`default_nettype none
// ============================================================================
// Module      : game_timer
// Description : Round countdown timer. A prescaler divides clk down to one
//               second; each second seconds_left and its BCD digits count
//               down, and game_finished rises on the 1->0 step and holds
//               until rst_ctl or a new start pulse.
// Ports       : clk                  in   system clock
//               rst                  in   synchronous active-high reset
//               game_enable          in   level, round may count while high
//               game_enable_posedge  in   1-cycle start/restart pulse
//               rst_ctl              in   1-cycle soft reset back to IDLE
//               game_finished        out  level, round time expired
//               sec_tick             out  1-cycle pulse per second decrement
//               seconds_left         out  7  binary seconds remaining
//               time_tens            out  4  BCD tens digit of seconds_left
//               time_ones            out  4  BCD ones digit of seconds_left
//               time_low             out  seconds_left <= LOW_SECONDS
//                                         (RUNNING/EXPIRED only)
// Revision    : 1.0 - initial release
// ============================================================================
module game_timer
    import game_pkg::*;
#(
    parameter int CLK_HZ       = 65_000_000,
    parameter int GAME_SECONDS = GAME_TIME_S,
    parameter int LOW_SECONDS  = LOW_TIME_S
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       game_enable,
    input  logic       game_enable_posedge,
    input  logic       rst_ctl,
    output logic       game_finished,
    output logic       sec_tick,
    output logic [6:0] seconds_left,
    output logic [3:0] time_tens,
    output logic [3:0] time_ones,
    output logic       time_low
);

    // A 1 Hz clock would give $clog2 = 0; keep at least one prescaler bit.
    localparam int               PRE_W       = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PRE_W-1:0] c_PRE_LAST  = PRE_W'(CLK_HZ - 1);
    localparam logic [6:0]       c_GAME_SECS = 7'(GAME_SECONDS);
    localparam logic [6:0]       c_LOW_SECS  = 7'(LOW_SECONDS);
    localparam logic [7:0]       c_GAME_BCD  = to_bcd(c_GAME_SECS);

    timer_state_t     r_state;
    timer_state_t     w_state_nxt;
    logic [PRE_W-1:0] r_prescaler;
    logic [PRE_W-1:0] w_prescaler_nxt;
    logic [6:0]       r_seconds;
    logic [6:0]       w_seconds_nxt;
    logic             r_finished;
    logic             w_finished_nxt;
    logic             r_sec_tick;
    logic             w_sec_tick_nxt;
    logic             r_time_low;
    logic             w_time_low_nxt;

    logic             w_count_en;
    logic             w_tick;
    logic             w_bcd_load;
    logic             w_bcd_zero;

    // Counting only happens when neither control pulse overrides this cycle.
    assign w_count_en = (r_state == RUNNING) && game_enable
                        && !rst_ctl && !game_enable_posedge;
    // The zero guard is redundant while RUNNING (seconds >= 1) but makes
    // underflow impossible regardless of state encoding.
    assign w_tick     = w_count_en && (r_prescaler == c_PRE_LAST) && !w_bcd_zero;
    assign w_bcd_load = rst_ctl || game_enable_posedge;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        if (rst_ctl) begin
            w_state_nxt = IDLE;
        end else if (game_enable_posedge) begin
            w_state_nxt = RUNNING;
        end else if (w_tick && (r_seconds == 7'd1)) begin
            w_state_nxt = EXPIRED;
        end
    end

    // ------------------------------------------------------------------
    // Output / datapath next values
    // ------------------------------------------------------------------
    always_comb begin
        w_prescaler_nxt = r_prescaler;
        w_seconds_nxt   = r_seconds;
        w_finished_nxt  = r_finished;
        w_sec_tick_nxt  = 1'b0;
        w_time_low_nxt  = r_time_low;
        if (rst_ctl) begin
            w_prescaler_nxt = '0;
            w_seconds_nxt   = c_GAME_SECS;
            w_finished_nxt  = 1'b0;
            w_time_low_nxt  = 1'b0;
        end else if (game_enable_posedge) begin
            w_prescaler_nxt = '0;
            w_seconds_nxt   = c_GAME_SECS;
            w_finished_nxt  = 1'b0;
            w_time_low_nxt  = (c_GAME_SECS <= c_LOW_SECS);
        end else begin
            if (w_count_en) begin
                w_prescaler_nxt = (r_prescaler == c_PRE_LAST) ? '0 : r_prescaler + PRE_W'(1);
            end
            if (w_tick) begin
                w_sec_tick_nxt = 1'b1;
                w_seconds_nxt  = r_seconds - 7'd1;
                if (r_seconds == 7'd1) begin
                    w_finished_nxt = 1'b1;
                end
            end
            // Registered from the post-edge seconds value so the flag moves
            // on the same edge as seconds_left.
            if (r_state == IDLE) begin
                w_time_low_nxt = 1'b0;
            end else begin
                w_time_low_nxt = (w_seconds_nxt <= c_LOW_SECS);
            end
        end
    end

    // ------------------------------------------------------------------
    // Output registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prescaler <= '0;
            r_seconds   <= c_GAME_SECS;
            r_finished  <= 1'b0;
            r_sec_tick  <= 1'b0;
            r_time_low  <= 1'b0;
        end else begin
            r_prescaler <= w_prescaler_nxt;
            r_seconds   <= w_seconds_nxt;
            r_finished  <= w_finished_nxt;
            r_sec_tick  <= w_sec_tick_nxt;
            r_time_low  <= w_time_low_nxt;
        end
    end

    bcd_down_counter #(
        .RESET_BCD (c_GAME_BCD)
    ) u_bcd (
        .clk        (clk),
        .rst        (rst),
        .load       (w_bcd_load),
        .load_value (c_GAME_BCD),
        .dec        (w_tick),
        .tens       (time_tens),
        .ones       (time_ones),
        .zero       (w_bcd_zero)
    );

    assign game_finished = r_finished;
    assign sec_tick      = r_sec_tick;
    assign seconds_left  = r_seconds;
    assign time_low      = r_time_low;

endmodule
`default_nettype wire

// File: tb/tb_game_timer.sv
`default_nettype none
// ============================================================================
// Module      : tb_game_timer
// Description : Self-checking bench for game_timer. Main instance uses
//               CLK_HZ=4, GAME_SECONDS=3, LOW_SECONDS=2; a second instance
//               with GAME_SECONDS=12 exercises the BCD borrow path.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_game_timer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       game_enable;
    logic       game_enable_posedge;
    logic       rst_ctl;
    logic       game_finished;
    logic       sec_tick;
    logic [6:0] seconds_left;
    logic [3:0] time_tens;
    logic [3:0] time_ones;
    logic       time_low;

    logic       b_enable;
    logic       b_posedge;
    logic       b_rst_ctl;
    logic       b_finished;
    logic       b_tick;
    logic [6:0] b_seconds;
    logic [3:0] b_tens;
    logic [3:0] b_ones;
    logic       b_low;

    game_timer #(
        .CLK_HZ       (4),
        .GAME_SECONDS (3),
        .LOW_SECONDS  (2)
    ) dut (
        .clk                 (clk),
        .rst                 (rst),
        .game_enable         (game_enable),
        .game_enable_posedge (game_enable_posedge),
        .rst_ctl             (rst_ctl),
        .game_finished       (game_finished),
        .sec_tick            (sec_tick),
        .seconds_left        (seconds_left),
        .time_tens           (time_tens),
        .time_ones           (time_ones),
        .time_low            (time_low)
    );

    game_timer #(
        .CLK_HZ       (4),
        .GAME_SECONDS (12),
        .LOW_SECONDS  (2)
    ) dut12 (
        .clk                 (clk),
        .rst                 (rst),
        .game_enable         (b_enable),
        .game_enable_posedge (b_posedge),
        .rst_ctl             (b_rst_ctl),
        .game_finished       (b_finished),
        .sec_tick            (b_tick),
        .seconds_left        (b_seconds),
        .time_tens           (b_tens),
        .time_ones           (b_ones),
        .time_low            (b_low)
    );

    int checks   = 0;
    int failures = 0;

    typedef struct {
        int k;
        int secs;
        int tens;
        int ones;
        int tk;
        int fin;
        int low;
    } vec_t;

    typedef struct {
        int secs;
        int tens;
        int ones;
        int low;
        int fin;
    } vec12_t;

    vec_t   run_tab[13];
    vec12_t bcd_tab[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check_main(input string tag, input int secs, input int tens, input int ones,
                              input int tk, input int fin, input int low);
        check($sformatf("%s seconds_left", tag), 32'(seconds_left), secs);
        check($sformatf("%s time_tens", tag), 32'(time_tens), tens);
        check($sformatf("%s time_ones", tag), 32'(time_ones), ones);
        check($sformatf("%s sec_tick", tag), 32'(sec_tick), tk);
        check($sformatf("%s game_finished", tag), 32'(game_finished), fin);
        check($sformatf("%s time_low", tag), 32'(time_low), low);
    endtask

    initial begin
        int cur_k;
        int e_secs;

        // k: cycles after the load edge; secs/tens/ones, tick, finished, low
        run_tab[0]  = '{1,  3, 0, 3, 0, 0, 0};
        run_tab[1]  = '{2,  3, 0, 3, 0, 0, 0};
        run_tab[2]  = '{3,  3, 0, 3, 0, 0, 0};
        run_tab[3]  = '{4,  2, 0, 2, 1, 0, 1};
        run_tab[4]  = '{5,  2, 0, 2, 0, 0, 1};
        run_tab[5]  = '{6,  2, 0, 2, 0, 0, 1};
        run_tab[6]  = '{7,  2, 0, 2, 0, 0, 1};
        run_tab[7]  = '{8,  1, 0, 1, 1, 0, 1};
        run_tab[8]  = '{9,  1, 0, 1, 0, 0, 1};
        run_tab[9]  = '{10, 1, 0, 1, 0, 0, 1};
        run_tab[10] = '{11, 1, 0, 1, 0, 0, 1};
        run_tab[11] = '{12, 0, 0, 0, 1, 1, 1};
        run_tab[12] = '{13, 0, 0, 0, 0, 1, 1};

        // GAME_SECONDS=12: state after each successive tick
        bcd_tab[0]  = '{11, 1, 1, 0, 0};
        bcd_tab[1]  = '{10, 1, 0, 0, 0};
        bcd_tab[2]  = '{9,  0, 9, 0, 0};
        bcd_tab[3]  = '{8,  0, 8, 0, 0};
        bcd_tab[4]  = '{7,  0, 7, 0, 0};
        bcd_tab[5]  = '{6,  0, 6, 0, 0};
        bcd_tab[6]  = '{5,  0, 5, 0, 0};
        bcd_tab[7]  = '{4,  0, 4, 0, 0};
        bcd_tab[8]  = '{3,  0, 3, 0, 0};
        bcd_tab[9]  = '{2,  0, 2, 1, 0};
        bcd_tab[10] = '{1,  0, 1, 1, 0};
        bcd_tab[11] = '{0,  0, 0, 1, 1};

        rst                 = 1'b1;
        game_enable         = 1'b0;
        game_enable_posedge = 1'b0;
        rst_ctl             = 1'b0;
        b_enable            = 1'b0;
        b_posedge           = 1'b0;
        b_rst_ctl           = 1'b0;

        // Reset
        step(2);
        check_main("reset", 3, 0, 3, 0, 0, 0);
        check("reset12 seconds_left", 32'(b_seconds), 12);
        check("reset12 time_tens", 32'(b_tens), 1);
        check("reset12 time_ones", 32'(b_ones), 2);
        rst = 1'b0;

        // IDLE with game_enable high but no start pulse: nothing counts
        game_enable = 1'b1;
        step(6);
        check_main("idle", 3, 0, 3, 0, 0, 0);

        // Full round from a start pulse
        game_enable_posedge = 1'b1;
        step(1);
        game_enable_posedge = 1'b0;
        cur_k = 0;
        for (int i = 0; i < 13; i++) begin
            step(run_tab[i].k - cur_k);
            cur_k = run_tab[i].k;
            check_main($sformatf("run k=%0d", cur_k), run_tab[i].secs, run_tab[i].tens,
                       run_tab[i].ones, run_tab[i].tk, run_tab[i].fin, run_tab[i].low);
        end

        // EXPIRED holds
        for (int i = 0; i < 20; i++) begin
            step(1);
            check($sformatf("hold %0d game_finished", i), 32'(game_finished), 1);
            check($sformatf("hold %0d seconds_left", i), 32'(seconds_left), 0);
            check($sformatf("hold %0d sec_tick", i), 32'(sec_tick), 0);
        end

        // Restart from EXPIRED, then pause edges 7..16
        game_enable_posedge = 1'b1;
        step(1);
        game_enable_posedge = 1'b0;
        check_main("restart", 3, 0, 3, 0, 0, 0);
        for (int k = 1; k <= 24; k++) begin
            step(1);
            if (k < 4)       e_secs = 3;
            else if (k < 18) e_secs = 2;
            else if (k < 22) e_secs = 1;
            else             e_secs = 0;
            check($sformatf("pause k=%0d seconds_left", k), 32'(seconds_left), e_secs);
            check($sformatf("pause k=%0d time_ones", k), 32'(time_ones), e_secs);
            check($sformatf("pause k=%0d sec_tick", k), 32'(sec_tick),
                  (k == 4 || k == 18 || k == 22) ? 1 : 0);
            check($sformatf("pause k=%0d game_finished", k), 32'(game_finished),
                  (k >= 22) ? 1 : 0);
            if (k == 6)  game_enable = 1'b0;
            if (k == 16) game_enable = 1'b1;
        end

        // rst_ctl mid-round
        game_enable_posedge = 1'b1;
        step(1);
        game_enable_posedge = 1'b0;
        step(4);
        check("ctl pre sec_tick", 32'(sec_tick), 1);
        check("ctl pre seconds_left", 32'(seconds_left), 2);
        rst_ctl = 1'b1;
        step(1);
        rst_ctl = 1'b0;
        check_main("rst_ctl", 3, 0, 3, 0, 0, 0);
        for (int i = 0; i < 10; i++) begin
            step(1);
            check($sformatf("ctl idle %0d sec_tick", i), 32'(sec_tick), 0);
            check($sformatf("ctl idle %0d seconds_left", i), 32'(seconds_left), 3);
        end

        // rst_ctl and start pulse in the same cycle: rst_ctl wins
        rst_ctl             = 1'b1;
        game_enable_posedge = 1'b1;
        step(1);
        rst_ctl             = 1'b0;
        game_enable_posedge = 1'b0;
        check_main("collide", 3, 0, 3, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            step(1);
            check($sformatf("collide %0d sec_tick", i), 32'(sec_tick), 0);
            check($sformatf("collide %0d seconds_left", i), 32'(seconds_left), 3);
            check($sformatf("collide %0d game_finished", i), 32'(game_finished), 0);
        end

        // GAME_SECONDS=12: BCD borrow sequence
        b_enable  = 1'b1;
        b_posedge = 1'b1;
        step(1);
        b_posedge = 1'b0;
        check("b load seconds_left", 32'(b_seconds), 12);
        for (int i = 0; i < 12; i++) begin
            step(3);
            check($sformatf("b pre %0d sec_tick", i), 32'(b_tick), 0);
            step(1);
            check($sformatf("b %0d seconds_left", i), 32'(b_seconds), bcd_tab[i].secs);
            check($sformatf("b %0d time_tens", i), 32'(b_tens), bcd_tab[i].tens);
            check($sformatf("b %0d time_ones", i), 32'(b_ones), bcd_tab[i].ones);
            check($sformatf("b %0d sec_tick", i), 32'(b_tick), 1);
            check($sformatf("b %0d time_low", i), 32'(b_low), bcd_tab[i].low);
            check($sformatf("b %0d game_finished", i), 32'(b_finished), bcd_tab[i].fin);
        end
        step(8);
        check("b expired seconds_left", 32'(b_seconds), 0);
        check("b expired time_tens", 32'(b_tens), 0);
        check("b expired game_finished", 32'(b_finished), 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
